// File: rtl/window_buffer_pkg.sv
// Shared definitions for window_buffer: helper macros and controller state encoding.
// Optional status outputs (out_row, out_col, frame_done) are enabled with WINDOW_BUFFER_STATUS_EN.
`ifndef WINDOW_BUFFER_DEFS
`define WINDOW_BUFFER_DEFS
`define LOG2(x) (((x) > 1) ? $clog2(x) : 1)
`define L(i, w) (((i) + 1) * (w) - 1)
`define R(i, w) ((i) * (w))
`endif

package window_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_LAST   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/block_ram.sv
// Single-port line memory: synchronous write, asynchronous read of the pre-write contents.
// Contents are never cleared; readers gate stale data themselves.
module block_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [`LOG2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/register.sv
// Enabled data register with asynchronous active-high clear.
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/window_buffer_ctrl.sv
// Raster counters, frame FSM and window eligibility for window_buffer.
// With WINDOW_BUFFER_STATUS_EN it also produces centre-tap coordinates and frame_done.
//
// state     | meaning
// ST_IDLE   | waiting for the first pixel of a frame
// ST_FILL   | priming the line buffers with the first FILTER_SIZE-1 rows
// ST_STREAM | windows are being produced
// ST_LAST   | final pixel of the frame accepted; one enabled cycle
module window_buffer_ctrl
  import window_buffer_pkg::*;
#(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32,
  parameter int STRIDE       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clk_en,
  input  logic                            in_valid,
  output logic                            accept,
  output logic [`LOG2(IMAGE_WIDTH)-1:0]   col,
  output logic                            out_valid
`ifdef WINDOW_BUFFER_STATUS_EN
  ,
  output logic [`LOG2(IMAGE_HEIGHT)-1:0]  out_row,
  output logic [`LOG2(IMAGE_WIDTH)-1:0]   out_col,
  output logic                            frame_done
`endif
);

  localparam int COL_W = `LOG2(IMAGE_WIDTH);
  localparam int ROW_W = `LOG2(IMAGE_HEIGHT);
  localparam int EDGE  = FILTER_SIZE - 1;
  localparam int HALF  = (FILTER_SIZE - 1) / 2;

  logic [ROW_W-1:0] row;
  logic             last_col, last_row;
  logic [ROW_W-1:0] row_off;
  logic [COL_W-1:0] col_off;
  logic             row_ok, col_ok, eligible;
  wb_state_t        state, state_next;

  assign accept   = clk_en & in_valid;
  assign last_col = (col == COL_W'(IMAGE_WIDTH - 1));
  assign last_row = (row == ROW_W'(IMAGE_HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Column test also keeps windows from straddling a row wrap.
  assign row_off  = row - ROW_W'(EDGE);
  assign col_off  = col - COL_W'(EDGE);
  assign row_ok   = (row >= ROW_W'(EDGE)) && ((row_off % ROW_W'(STRIDE)) == '0);
  assign col_ok   = (col >= COL_W'(EDGE)) && ((col_off % COL_W'(STRIDE)) == '0);
  assign eligible = row_ok & col_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (accept) state_next = ST_FILL;
      ST_FILL:   if (accept && row == ROW_W'(EDGE) && col == '0) state_next = ST_STREAM;
      ST_STREAM: if (accept && last_col && last_row) state_next = ST_LAST;
      ST_LAST:   if (clk_en) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_valid <= 1'b0;
    else if (clk_en) out_valid <= in_valid & eligible;
  end

`ifdef WINDOW_BUFFER_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (accept && eligible) begin
      out_row <= row - ROW_W'(HALF);
      out_col <= col - COL_W'(HALF);
    end
  end

  assign frame_done = (state == ST_LAST);
`endif

endmodule

// File: rtl/window_buffer.sv
// Sliding FILTER_SIZE x FILTER_SIZE window over a raster pixel stream, built from line buffers and a tap array.
// Define WINDOW_BUFFER_STATUS_EN to add out_row, out_col and frame_done.
module window_buffer
  import window_buffer_pkg::*;
#(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32,
  parameter int D_WIDTH      = 8,
  parameter int CHANNELS     = 1,
  parameter int STRIDE       = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 clk_en,
  input  logic                                                 in_valid,
  input  logic [D_WIDTH*CHANNELS-1:0]                          in_data,
  output logic                                                 out_valid,
  output logic [D_WIDTH*CHANNELS*FILTER_SIZE*FILTER_SIZE-1:0]  out_data
`ifdef WINDOW_BUFFER_STATUS_EN
  ,
  output logic [`LOG2(IMAGE_HEIGHT)-1:0]                       out_row,
  output logic [`LOG2(IMAGE_WIDTH)-1:0]                        out_col,
  output logic                                                 frame_done
`endif
);

  localparam int PIX_W = D_WIDTH * CHANNELS;
  localparam int COL_W = `LOG2(IMAGE_WIDTH);

  logic             accept;
  logic [COL_W-1:0] col;
  logic [PIX_W-1:0] col_new [FILTER_SIZE];
  logic [PIX_W-1:0] lb_rd   [FILTER_SIZE-1];
  logic [PIX_W-1:0] tap_q   [FILTER_SIZE][FILTER_SIZE];

  window_buffer_ctrl #(
    .FILTER_SIZE  (FILTER_SIZE),
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .STRIDE       (STRIDE)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .in_valid   (in_valid),
    .accept     (accept),
    .col        (col),
    .out_valid  (out_valid)
`ifdef WINDOW_BUFFER_STATUS_EN
    ,
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
`endif
  );

  assign col_new[FILTER_SIZE-1] = in_data;

  // Line buffer j holds row (current - (FILTER_SIZE-1-j)); rows cascade towards index 0 on each write.
  for (genvar j = 0; j < FILTER_SIZE - 1; j++) begin : g_line
    logic [PIX_W-1:0] wr_data;

    if (j == FILTER_SIZE - 2) begin : g_top
      assign wr_data = in_data;
    end else begin : g_mid
      assign wr_data = lb_rd[j+1];
    end

    block_ram #(
      .DATA_W (PIX_W),
      .DEPTH  (IMAGE_WIDTH)
    ) u_lb (
      .clk     (clk),
      .we      (accept),
      .addr    (col),
      .wr_data (wr_data),
      .rd_data (lb_rd[j])
    );

    assign col_new[j] = lb_rd[j];
  end

  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_col
      logic [PIX_W-1:0] d;

      if (c == FILTER_SIZE - 1) begin : g_newest
        assign d = col_new[r];
      end else begin : g_shift
        assign d = tap_q[r][c+1];
      end

      register #(.WIDTH(PIX_W)) u_tap (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (d),
        .q   (tap_q[r][c])
      );

      assign out_data[`L(r*FILTER_SIZE+c, PIX_W):`R(r*FILTER_SIZE+c, PIX_W)] = tap_q[r][c];
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer: three instances (stride 1, stride 2, three channels) on an 8x6 image,
// checked every cycle against a frame-array reference model.
module tb_window_buffer;

  localparam int F = 3;
  localparam int W = 8;
  localparam int H = 6;

  typedef int idx9_t [9];

  logic         clk = 1'b0;
  logic         rst, clk_en, in_valid;
  logic [7:0]   data_a;
  logic [23:0]  data_c;
  logic         ov_a, ov_s, ov_c;
  logic [71:0]  od_a, od_s;
  logic [215:0] od_c;
`ifdef WINDOW_BUFFER_STATUS_EN
  logic [2:0]   orow_a, ocol_a, orow_s, ocol_s, orow_c, ocol_c;
  logic         fd_a, fd_s, fd_c;
`endif

  always #5 clk = ~clk;

  window_buffer #(.FILTER_SIZE(F), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .D_WIDTH(8), .CHANNELS(1), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_data(data_a),
    .out_valid(ov_a), .out_data(od_a)
`ifdef WINDOW_BUFFER_STATUS_EN
    , .out_row(orow_a), .out_col(ocol_a), .frame_done(fd_a)
`endif
  );

  window_buffer #(.FILTER_SIZE(F), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .D_WIDTH(8), .CHANNELS(1), .STRIDE(2)) dut_s (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_data(data_a),
    .out_valid(ov_s), .out_data(od_s)
`ifdef WINDOW_BUFFER_STATUS_EN
    , .out_row(orow_s), .out_col(ocol_s), .frame_done(fd_s)
`endif
  );

  window_buffer #(.FILTER_SIZE(F), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .D_WIDTH(8), .CHANNELS(3), .STRIDE(1)) dut_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_data(data_c),
    .out_valid(ov_c), .out_data(od_c)
`ifdef WINDOW_BUFFER_STATUS_EN
    , .out_row(orow_c), .out_col(ocol_c), .frame_done(fd_c)
`endif
  );

  // Reference model: the current frame as a 2-D array plus the raster position of the next pixel.
  logic [7:0]   img [0:H-1][0:W-1];
  int           m_row, m_col;
  bit           ev_a, ev_s, ev_c, exp_fd;
  logic [255:0] ew_a, ew_s, ew_c;
  int           exp_orow, exp_ocol;
  int           win_a, win_s, fd_cnt;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit elig(input int r, input int c, input int s);
    return (r >= F-1) && (c >= F-1) && ((r-(F-1)) % s == 0) && ((c-(F-1)) % s == 0);
  endfunction

  function automatic logic [255:0] window(input int r0, input int c0, input bit three);
    logic [255:0] w = '0;
    logic [7:0]   p;
    for (int rr = 0; rr < F; rr++) begin
      for (int cc = 0; cc < F; cc++) begin
        p = img[r0-(F-1)+rr][c0-(F-1)+cc];
        if (three) begin
          w[(rr*F+cc)*24 +: 8]      = p;
          w[(rr*F+cc)*24 + 8 +: 8]  = 8'(p + 8'd64);
          w[(rr*F+cc)*24 + 16 +: 8] = 8'(p + 8'd128);
        end else begin
          w[(rr*F+cc)*8 +: 8] = p;
        end
      end
    end
    return w;
  endfunction

  function automatic logic [255:0] pack9(input idx9_t q);
    logic [255:0] w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(q[k]);
    return w;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0;
    ev_a = 0; ev_s = 0; ev_c = 0; exp_fd = 0;
  endtask

  task automatic step(input bit v, input bit e, input logic [7:0] val);
    in_valid = v;
    clk_en   = e;
    data_a   = val;
    data_c   = {val + 8'd128, val + 8'd64, val};
    @(posedge clk);
    if (e) begin
      ev_a = 0; ev_s = 0; ev_c = 0; exp_fd = 0;
      if (v) begin
        img[m_row][m_col] = val;
        if (elig(m_row, m_col, 1)) begin
          ev_a = 1; ev_c = 1;
          ew_a = window(m_row, m_col, 0);
          ew_c = window(m_row, m_col, 1);
          exp_orow = m_row - (F-1)/2;
          exp_ocol = m_col - (F-1)/2;
        end
        if (elig(m_row, m_col, 2)) begin
          ev_s = 1;
          ew_s = window(m_row, m_col, 0);
        end
        if (m_row == H-1 && m_col == W-1) exp_fd = 1;
        if (m_col == W-1) begin
          m_col = 0;
          m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end
    #1;
    check("valid_s1", ov_a, ev_a);
    check("valid_s2", ov_s, ev_s);
    check("valid_c3", ov_c, ev_c);
    if (ev_a) check("data_s1", od_a, ew_a);
    if (ev_s) check("data_s2", od_s, ew_s);
    if (ev_c) check("data_c3", od_c, ew_c);
    if (e && ov_a) win_a++;
    if (e && ov_s) win_s++;
`ifdef WINDOW_BUFFER_STATUS_EN
    if (e) begin
      check("frame_done", fd_a, exp_fd);
      if (fd_a) fd_cnt++;
    end
    if (ev_a) begin
      check("out_row", orow_a, exp_orow);
      check("out_col", ocol_a, exp_ocol);
    end
`endif
  endtask

  task automatic run_basic();
    int           first = -1;
    int           nsec  = 0;
    logic [7:0]   centre = '0;
    idx9_t        q_first  = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    idx9_t        q_second = '{2, 3, 4, 10, 11, 12, 18, 19, 20};
    win_a = 0; win_s = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, 1'b1, 8'(i));
      if (ov_a) begin
        if (first < 0) begin
          first = i;
          check("basic_first_window", od_a, pack9(q_first));
          check("c3_tap00", od_c[23:0], 24'h804000);
        end
        centre = od_a[39:32];
      end
      if (ov_s) begin
        nsec++;
        if (nsec == 2) check("s2_second_window", od_s, pack9(q_second));
      end
    end
    check("basic_first_pixel", first, 18);
    check("basic_count_s1", win_a, 24);
    check("basic_count_s2", win_s, 6);
    check("basic_last_centre", centre, 8'd38);
  endtask

  initial begin
    int  accepted;
    int  r;
    bit  seen;
    rst = 1'b1; clk_en = 1'b0; in_valid = 1'b0; data_a = '0; data_c = '0;
    fd_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_s1", ov_a, 1'b0);
    check("reset_data_s1", od_a, '0);
    check("reset_data_c3", od_c, '0);
    rst = 1'b0;

    run_basic();

    win_a = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, 1'b1, 8'(i));
      step(1'b0, 1'b1, 8'hAA);
      step(1'b1, 1'b0, 8'h55);
    end
    check("toggle_count_s1", win_a, 24);

    for (int i = 0; i <= 20; i++) step(1'b1, 1'b1, 8'(i));
    rst = 1'b1;
    #1;
    check("midrst_valid_s1", ov_a, 1'b0);
    check("midrst_valid_s2", ov_s, 1'b0);
    check("midrst_data_s1", od_a, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_basic();

    win_a = 0; fd_cnt = 0; accepted = 0; seen = 0;
    while (accepted < 2*W*H) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        step(1'b0, 1'b1, 8'($urandom));
      end else if (r == 1) begin
        step(1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
      end else begin
        step(1'b1, 1'b1, 8'($urandom));
        accepted++;
`ifdef WINDOW_BUFFER_STATUS_EN
        if (ov_a && !seen) begin
          seen = 1;
          check("first_out_row", orow_a, 3'd1);
          check("first_out_col", ocol_a, 3'd1);
        end
`endif
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    check("random_count_s1", win_a, 48);
`ifdef WINDOW_BUFFER_STATUS_EN
    check("frame_done_pulses", fd_cnt, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter FILTER_SIZE, default 3: window side in pixels, odd, 3 to 7.
REQ-002 Parameter IMAGE_WIDTH, default 32: pixels per row.
REQ-003 Parameter IMAGE_HEIGHT, default 32: rows per frame.
REQ-004 Parameter D_WIDTH, default 8: bits per channel sample.
REQ-005 Parameter CHANNELS, default 1: samples per pixel, 1 to 4.
REQ-006 Parameter STRIDE, default 1: window step in both axes, 1 to FILTER_SIZE.
REQ-007 Port clk, input, 1 bit: single clock.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port clk_en, input, 1 bit: global enable; when low, all state holds.
REQ-010 Port in_valid, input, 1 bit: in_data carries the next raster-order pixel.
REQ-011 Port in_data, input, D_WIDTH*CHANNELS bits: pixel; channel k at bits [k*D_WIDTH +: D_WIDTH].
REQ-012 Port out_valid, output, 1 bit: out_data holds a complete window.
REQ-013 Port out_data, output, D_WIDTH*CHANNELS*FILTER_SIZE*FILTER_SIZE bits: tap (r,c) at pixel slot r*FILTER_SIZE+c; r=0 is the oldest row and c=0 the oldest column.

Function
REQ-014 A pixel SHALL be accepted on a rising clk edge with clk_en=1 and in_valid=1; there is no backpressure.
REQ-015 Internal col and row counters SHALL advance on each accepted pixel in raster order, wrapping col at IMAGE_WIDTH-1 and row at IMAGE_HEIGHT-1.
REQ-016 FILTER_SIZE-1 line buffers of depth IMAGE_WIDTH SHALL hold prior rows, with each row CHANNELS*D_WIDTH wide.
REQ-017 The controller FSM SHALL have states IDLE, FILL, STREAM and LAST, with these transitions:
- IDLE to FILL on the first accepted pixel.
- FILL to STREAM on the accepted pixel with row=FILTER_SIZE-1 and col=0.
- STREAM to LAST when the pixel at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) is accepted.
- LAST to IDLE unconditionally after one enabled cycle.
REQ-018 A window SHALL be eligible when row>=FILTER_SIZE-1, col>=FILTER_SIZE-1, (row-(FILTER_SIZE-1)) mod STRIDE=0 and (col-(FILTER_SIZE-1)) mod STRIDE=0.
- These tests are evaluated on the counters of the accepted pixel.
REQ-019 out_valid SHALL assert for exactly one enabled cycle, one clock after acceptance of the pixel that completes an eligible window (latency 1).
REQ-020 out_data SHALL be registered, change only on accepted pixels, and hold its value otherwise.
REQ-021 Windows SHALL never span a row wrap: no window is eligible where col<FILTER_SIZE-1.
REQ-022 Gaps in in_valid SHALL not alter the window contents or the window count.
REQ-023 Back-to-back frames SHALL need no idle cycle: a pixel accepted while the FSM is in LAST is row 0, col 0 of the next frame.
REQ-024 With clk_en=0, out_valid SHALL hold its value, and counters, FSM and buffers SHALL hold.
REQ-025 Each frame SHALL produce ((IMAGE_HEIGHT-FILTER_SIZE)/STRIDE+1)*((IMAGE_WIDTH-FILTER_SIZE)/STRIDE+1) windows, with integer division.

Reset
REQ-026 rst=1 SHALL immediately force out_valid=0, out_data=0, the counters to 0 and the FSM to IDLE.
REQ-027 Line buffer contents SHALL not be cleared; stale data is never output, because REQ-018 gates eligibility.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after release is (0,0).

Configuration
REQ-029 Macro WINDOW_BUFFER_STATUS_EN, when defined, SHALL add the following outputs, all reset to 0:
- out_row and out_col, LOG2(IMAGE_HEIGHT) and LOG2(IMAGE_WIDTH) bits: centre-tap coordinates, valid with out_valid.
- frame_done, 1 bit: pulses one cycle in LAST.
REQ-030 Without WINDOW_BUFFER_STATUS_EN, these ports and their logic SHALL be absent, and the behaviour of all other ports is unchanged.

Structure
REQ-031 The LOG2, L and R helper macros and the FSM state encodings SHALL live in the shared definitions file.
REQ-032 Line buffers SHALL instantiate the existing block_ram, and tap registers SHALL instantiate the existing register.
REQ-033 The counter, FSM and eligibility logic SHALL form sub-module window_buffer_ctrl.

Verification
REQ-034 The bench SHALL cover these directed scenarios. Unless stated, F=3, W=8, H=6, D=8, C=1, S=1, pixel value = raster index 0..47, and in_valid is held high.
- Basic: first out_valid one clk after pixel 18; window {0,1,2,8,9,10,16,17,18}; 24 windows per frame; last window centre 38.
- S=2: 6 windows; second window {2,3,4,10,11,12,18,19,20}.
- in_valid toggling 1/0 with clk_en toggling low: same 24 windows in the same order.
- C=3, channel k = index+64*k: the tap (0,0) slot of the first window holds channel0=0, channel1=64, channel2=128.
- rst pulsed after pixel 20: out_valid=0 at once; the restarted frame matches the Basic scenario.
- Two frames back-to-back with WINDOW_BUFFER_STATUS_EN: frame_done pulses twice; first window out_row=1, out_col=1; 48 windows in total.
